// File: rtl/pipe_chain.sv
// Generic pipeline skeleton: per-stage valid bits, the allow_in back-pressure chain,
// inter-stage bus registers, per-stage flush, and saturating retire/stall counters.
module pipe_chain #(
    parameter int STAGES = 5,
    parameter int BUS_W  = 64,
    parameter int CNT_W  = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    input  logic [BUS_W-1:0]        in_bus_i,
    output logic                    in_ready_o,
    input  logic [STAGES-1:0]       stage_over_i,
    input  logic [STAGES*BUS_W-1:0] stage_bus_i,
    input  logic [STAGES-1:0]       flush_i,
    output logic [STAGES-1:0]       stage_valid_o,
    output logic [STAGES-1:0]       stage_allow_o,
    output logic [STAGES*BUS_W-1:0] stage_bus_o,
    output logic                    retire_o,
    input  logic                    cnt_clr_i,
    output logic [CNT_W-1:0]        retire_cnt_o,
    output logic [CNT_W-1:0]        stall_cnt_o
);
    localparam int LAST = STAGES - 1;

    // Handshake: a token moves from stage k-1 into stage k on an edge where
    // w_handoff[k-1] (valid, over, not flushed) and w_allow[k] are both high.
    // Stage 0 takes in_valid_i/in_bus_i under the same rule with in_ready_o = w_allow[0].
    logic [STAGES-1:0] w_valid;
    logic [STAGES-1:0] w_allow;
    logic [STAGES-1:0] w_handoff;
    logic              w_retire;
    logic              w_stall;
    logic              w_unused;
    logic [CNT_W-1:0]  r_retire_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;

    // Allow ripples from the WB end; the last stage sees an always-ready sink.
    always_comb begin : allow_chain
        logic w_down;
        w_allow = '0;
        w_down  = 1'b1;
        for (int k = LAST; k >= 0; k--) begin
            w_down     = ~w_valid[k] | flush_i[k] | (stage_over_i[k] & w_down);
            w_allow[k] = w_down;
        end
    end

    assign w_handoff = w_valid & stage_over_i & ~flush_i;
    assign w_retire  = w_handoff[LAST];
    assign w_stall   = in_valid_i & ~w_allow[0];
    assign w_unused  = ^stage_bus_i[LAST*BUS_W +: BUS_W];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             r_valid;
        logic [BUS_W-1:0] r_bus;
        logic             w_take;
        logic [BUS_W-1:0] w_src;

        if (k == 0) begin : g_head
            assign w_take = in_valid_i;
            assign w_src  = in_bus_i;
        end else begin : g_body
            assign w_take = w_handoff[k-1];
            assign w_src  = stage_bus_i[(k-1)*BUS_W +: BUS_W];
        end

        // Bus only loads on a real handoff so a bubble keeps the last payload visible.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_valid <= 1'b0;
                r_bus   <= '0;
            end else if (w_allow[k]) begin
                r_valid <= w_take;
                if (w_take) begin
                    r_bus <= w_src;
                end
            end else begin
                r_valid <= r_valid & ~flush_i[k];
            end
        end

        assign w_valid[k]                     = r_valid;
        assign stage_bus_o[k*BUS_W +: BUS_W]  = r_bus;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || cnt_clr_i) begin
            r_retire_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (w_retire && (r_retire_cnt != '1)) begin
                r_retire_cnt <= r_retire_cnt + 1'b1;
            end
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign in_ready_o    = w_allow[0];
    assign stage_valid_o = w_valid;
    assign stage_allow_o = w_allow;
    assign retire_o      = w_retire;
    assign retire_cnt_o  = r_retire_cnt;
    assign stall_cnt_o   = r_stall_cnt;
endmodule
